// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - seven-segment scan bus read-back with glitch filter and frame reassembly
// Optional scan stall detector is compiled in when SEG_SCAN_TIMEOUT_EN is defined.
module seg_scan_capture #(
    parameter int STABLE_CNT     = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       uclock,
    input  logic       reset,
    input  logic [3:0] AN,
    input  logic [6:0] LED,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       an_err
`ifdef SEG_SCAN_TIMEOUT_EN
    ,
    output logic       scan_stall
`endif
);

    typedef enum logic {COLLECT, COMMIT} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    state_t          state_q, state_d;
    logic [3:0]      an_s1_q, an_s1_d, an_s2_q, an_s2_d;
    logic [6:0]      led_s1_q, led_s1_d, led_s2_q, led_s2_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      seen_q, seen_d;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic            sh_seg_err_q, sh_seg_err_d;
    logic            sh_an_err_q, sh_an_err_d;
    logic [3:0][3:0] digit_q, digit_d;
    logic            frame_valid_q, frame_valid_d;
    logic            seg_err_q, seg_err_d;
    logic            an_err_q, an_err_d;
    logic            same, accept, commit;
    logic [3:0]      an_low;
    logic [4:0]      dec;

    // Returns {undecodable, digit}; blank maps to F without flagging an error.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h10:   decode = 5'h09;
            7'h7F:   decode = 5'h0F;
            default: decode = 5'h1E;
        endcase
    endfunction

    always_comb begin
        an_s1_d  = AN;
        an_s2_d  = an_s1_q;
        led_s1_d = LED;
        led_s2_d = led_s1_q;

        // The counter advances on the same edge the synchronized value updates,
        // so a pattern is accepted on its STABLE_CNT-th synchronized cycle.
        same   = (an_s1_q == an_s2_q) && (led_s1_q == led_s2_q);
        accept = same && (cnt_q == STABLE - 4'd1);
        if (!same)
            cnt_d = 4'd1;
        else if (cnt_q == STABLE)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 4'd1;

        commit = (state_q == COLLECT) && (seen_q == 4'hF);
        an_low = ~an_s2_q;
        dec    = decode(led_s2_q);

        // An accept landing on the commit edge belongs to the next frame.
        seen_d       = commit ? 4'h0 : seen_q;
        sh_seg_err_d = commit ? 1'b0 : sh_seg_err_q;
        sh_an_err_d  = commit ? 1'b0 : sh_an_err_q;
        shadow_d     = shadow_q;
        if (accept && (an_low != 4'h0)) begin
            if ((an_low & (an_low - 4'd1)) == 4'h0) begin
                for (int i = 0; i < 4; i++) begin
                    if (an_low[i]) begin
                        shadow_d[i] = dec[3:0];
                        seen_d[i]   = 1'b1;
                    end
                end
                sh_seg_err_d = sh_seg_err_d | dec[4];
            end else begin
                sh_an_err_d = 1'b1;
            end
        end

        digit_d       = commit ? shadow_q : digit_q;
        seg_err_d     = commit ? sh_seg_err_q : seg_err_q;
        an_err_d      = commit ? sh_an_err_q : an_err_q;
        frame_valid_d = commit;
        state_d       = commit ? COMMIT : COLLECT;
    end

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            state_q       <= COLLECT;
            an_s1_q       <= '1;
            an_s2_q       <= '1;
            led_s1_q      <= '1;
            led_s2_q      <= '1;
            cnt_q         <= '0;
            seen_q        <= '0;
            shadow_q      <= '1;
            sh_seg_err_q  <= 1'b0;
            sh_an_err_q   <= 1'b0;
            digit_q       <= '1;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            an_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            an_s1_q       <= an_s1_d;
            an_s2_q       <= an_s2_d;
            led_s1_q      <= led_s1_d;
            led_s2_q      <= led_s2_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            sh_seg_err_q  <= sh_seg_err_d;
            sh_an_err_q   <= sh_an_err_d;
            digit_q       <= digit_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
            an_err_q      <= an_err_d;
        end
    end

    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign digit3      = digit_q[3];
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign an_err      = an_err_q;

`ifdef SEG_SCAN_TIMEOUT_EN
    localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          scan_stall_q, scan_stall_d;

    // Cleared on the commit edge so scan_stall drops together with frame_valid rising.
    always_comb begin
        if (commit)
            to_cnt_d = '0;
        else if (to_cnt_q == TMAX)
            to_cnt_d = to_cnt_q;
        else
            to_cnt_d = to_cnt_q + 1'b1;
        if (commit)
            scan_stall_d = 1'b0;
        else if (to_cnt_d == TMAX)
            scan_stall_d = 1'b1;
        else
            scan_stall_d = scan_stall_q;
    end

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            to_cnt_q     <= '0;
            scan_stall_q <= 1'b0;
        end else begin
            to_cnt_q     <= to_cnt_d;
            scan_stall_q <= scan_stall_d;
        end
    end

    assign scan_stall = scan_stall_q;
`else
    logic cfg_unused;
    assign cfg_unused = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - self-checking bench for seg_scan_capture
module tb_seg_scan_capture;
    localparam int S   = 4;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an  = 4'hF;
    logic [6:0] led = 7'h7F;
    logic [3:0] d0, d1, d2, d3;
    logic       fv, se, ae;
`ifdef SEG_SCAN_TIMEOUT_EN
    logic       stall;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    seg_scan_capture #(.STABLE_CNT(S), .TIMEOUT_CYCLES(TMO)) dut (
        .uclock(clk), .reset(rst), .AN(an), .LED(led),
        .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
        .frame_valid(fv), .seg_err(se), .an_err(ae)
`ifdef SEG_SCAN_TIMEOUT_EN
        , .scan_stall(stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] dig; logic seg; logic an; } frame_t;
    typedef struct { logic [6:0] led; logic [3:0] dig; logic err; } vec_t;

    logic [6:0]  tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_seen;
    logic        m_seg, m_an;
    frame_t      exp_q [$];
    frame_t      mon_f;
    logic [10:0] run_pat = {4'hF, 7'h7F};
    int          run_len = 100;
    vec_t        vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit lookup(input logic [6:0] l, output logic [3:0] d);
        d = 4'hE;
        if (l == 7'h7F) begin d = 4'hF; return 1'b1; end
        for (int i = 0; i < 10; i++) if (tab[i] == l) begin d = 4'(i); return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_seen = 4'h0; m_seg = 1'b0; m_an = 1'b0;
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'hF;
        exp_q.delete();
    endtask

    // Frame-level model: every run of a pattern lasting S cycles is one accepted sample.
    task automatic model_accept(input logic [3:0] a, input logic [6:0] l);
        int lows = 0; int idx = 0; logic [3:0] d; bit ok; frame_t f;
        for (int i = 0; i < 4; i++) if (!a[i]) begin lows++; idx = i; end
        if (lows == 0) return;
        if (lows > 1) begin m_an = 1'b1; return; end
        ok = lookup(l, d);
        m_shadow[idx] = d;
        if (!ok) m_seg = 1'b1;
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
            f.dig = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
            f.seg = m_seg; f.an = m_an;
            exp_q.push_back(f);
            m_seen = 4'h0; m_seg = 1'b0; m_an = 1'b0;
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] l, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            an = a; led = l;
            if ({a, l} == run_pat) run_len++;
            else begin run_pat = {a, l}; run_len = 1; end
            if (run_len == S && !rst) model_accept(a, l);
        end
    endtask

    task automatic dig(input logic [3:0] a, input logic [6:0] l);
        hold(a, l, 8);
        hold(4'hF, 7'h7F, 2);
    endtask

    task automatic scan(input logic [6:0] p0, p1, p2, p3);
        dig(4'hE, p0); dig(4'hD, p1); dig(4'hB, p2); dig(4'h7, p3);
    endtask

    task automatic drain();
        hold(4'hF, 7'h7F, 12);
    endtask

    task automatic chk_frame(input string name, input logic [15:0] dg, input logic s, input logic a);
        chk({name, "_digits"}, {d3, d2, d1, d0}, dg);
        chk({name, "_seg_err"}, se, s);
        chk({name, "_an_err"}, ae, a);
    endtask

    always @(negedge clk) begin
        if (!rst && fv) begin
            pulses++;
            if (exp_q.size() == 0) begin
                chk("frame_unexpected", 1, 0);
            end else begin
                mon_f = exp_q.pop_front();
                chk("frame_model", {d3, d2, d1, d0, se, ae}, {mon_f.dig, mon_f.seg, mon_f.an});
            end
        end
    end

    initial begin
        int p0; int pos; int kind; int len; int gap;
        logic [3:0] a; logic [6:0] l; logic [3:0] dd;

        vecs[0]  = '{7'h40, 4'h0, 1'b0};  vecs[1]  = '{7'h79, 4'h1, 1'b0};
        vecs[2]  = '{7'h24, 4'h2, 1'b0};  vecs[3]  = '{7'h30, 4'h3, 1'b0};
        vecs[4]  = '{7'h19, 4'h4, 1'b0};  vecs[5]  = '{7'h12, 4'h5, 1'b0};
        vecs[6]  = '{7'h02, 4'h6, 1'b0};  vecs[7]  = '{7'h78, 4'h7, 1'b0};
        vecs[8]  = '{7'h00, 4'h8, 1'b0};  vecs[9]  = '{7'h10, 4'h9, 1'b0};
        vecs[10] = '{7'h7F, 4'hF, 1'b0};  vecs[11] = '{7'h55, 4'hE, 1'b1};
        vecs[12] = '{7'h7E, 4'hE, 1'b1};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_frame("reset", 16'hFFFF, 1'b0, 1'b0);
        chk("reset_fv", fv, 0);
        rst = 1'b0;

        // Basic scan 1,2,3,4
        p0 = pulses;
        scan(tab[1], tab[2], tab[3], tab[4]);
        drain();
        chk("basic_pulses", pulses - p0, 1);
        chk_frame("basic", 16'h4321, 1'b0, 1'b0);

        // Decode table on digit0
        for (int v = 0; v < 13; v++) begin
            scan(vecs[v].led, tab[1], tab[2], tab[3]);
            drain();
            chk("table_digit0", d0, vecs[v].dig);
            chk("table_seg_err", se, vecs[v].err);
        end

        // Glitch before settling on digit2
        dig(4'hE, tab[1]); dig(4'hD, tab[2]);
        hold(4'hB, 7'h3F, 2); hold(4'hB, 7'h30, 6); hold(4'hF, 7'h7F, 2);
        dig(4'h7, tab[4]);
        drain();
        chk_frame("glitch", 16'h4321, 1'b0, 1'b0);

        // Undecodable pattern, then a clean frame clears the flag
        scan(tab[1], tab[2], 7'h55, tab[4]);
        drain();
        chk_frame("bad_seg", 16'h4E21, 1'b1, 1'b0);
        scan(tab[1], tab[2], tab[3], tab[4]);
        drain();
        chk_frame("bad_seg_clear", 16'h4321, 1'b0, 1'b0);

        // Two anodes low inside a frame
        dig(4'hE, tab[1]); dig(4'hC, tab[7]); dig(4'hD, tab[2]);
        dig(4'hB, tab[3]); dig(4'h7, tab[4]);
        drain();
        chk_frame("an_err", 16'h4321, 1'b0, 1'b1);

        // Exact latency from last digit pin change to frame_valid
        dig(4'hE, tab[9]); dig(4'hD, tab[8]); dig(4'hB, tab[7]);
        hold(4'h7, tab[6], 1);
        for (int j = 1; j <= 8; j++) begin
            hold(4'h7, tab[6], 1);
            chk("latency_fv", fv, (j == S + 2) ? 1 : 0);
        end
        drain();
        chk_frame("latency", 16'h6789, 1'b0, 1'b0);

        // Reset mid-frame discards the partial frame
        dig(4'hE, tab[0]); dig(4'hD, tab[0]); dig(4'hB, tab[0]);
        rst = 1'b1;
        #2;
        chk_frame("rst_async", 16'hFFFF, 1'b0, 1'b0);
        hold(4'hF, 7'h7F, 2);
        chk_frame("rst_hold", 16'hFFFF, 1'b0, 1'b0);
        chk("rst_fv", fv, 0);
        model_reset();
        rst = 1'b0;
        p0 = pulses;
        scan(tab[5], tab[6], tab[7], tab[8]);
        drain();
        chk("rst_pulses", pulses - p0, 1);
        chk_frame("rst_frame", 16'h8765, 1'b0, 1'b0);

        // Randomized scanning against the frame-level model
        p0 = pulses;
        for (int r = 0; r < 300; r++) begin
            pos  = $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            a    = ~(4'b0001 << pos);
            l    = tab[$urandom_range(0, 9)];
            if (kind == 7) l = 7'h7F;
            if (kind == 8) begin
                do l = 7'($urandom); while (lookup(l, dd));
            end
            if (kind == 9) a = a & ~(4'b0001 << ((pos + 1) % 4));
            len = $urandom_range(1, 9);
            gap = $urandom_range(0, 3);
            hold(a, l, len);
            if (gap > 0) hold(4'hF, 7'h7F, gap);
        end
        drain();
        chk("random_queue_empty", exp_q.size(), 0);
        chk("random_some_frames", (pulses - p0) > 5 ? 1 : 0, 1);

`ifdef SEG_SCAN_TIMEOUT_EN
        rst = 1'b1;
        hold(4'hF, 7'h7F, 2);
        model_reset();
        rst = 1'b0;
        for (int c = 1; c <= TMO + 50; c++) begin
            hold(4'hF, 7'h7F, 1);
            if (c == TMO - 1) chk("stall_before", stall, 0);
            if (c == TMO) chk("stall_at", stall, 1);
        end
        chk("stall_hold", stall, 1);
        scan(tab[1], tab[2], tab[3], tab[4]);
        drain();
        chk("stall_cleared", stall, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Read-back receiver for the multiplexed four-digit seven-segment display bus of the watch. Samples the anode-select and segment lines driven by the display multiplexer, filters scan glitches, and decodes each segment pattern back to a BCD digit. It reassembles complete four-digit frames. Used for on-board self-test and debug readout of what the display actually shows, including time, stopwatch and alarm modes.

## Interface
- STABLE_CNT, 4: consecutive identical samples required before a digit is accepted (range 2–15).
- TIMEOUT_CYCLES, 2000000: cycles without a completed frame before a stall is flagged. Used only with the configuration macro.
- uclock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- AN  in  4  anode selects, active-low; AN[i] low selects digit i.
- LED  in  7  segment lines, active-low; LED[0]=a … LED[6]=g.
- digit0..digit3  out  4 each  decoded digits of the last committed frame.
- frame_valid  out  1  one-cycle pulse when digit0..3 are updated.
- seg_err  out  1  the last committed frame contained an undecodable pattern.
- an_err  out  1  the last committed frame saw more than one anode low.
- scan_stall  out  1  present only with the configuration macro; see Configuration.

## Operation
- AN and LED each pass through a two-flop synchronizer. All further logic uses the synchronized values.
- Stability filter:
  - A 4-bit counter counts cycles for which {AN, LED} is unchanged. Any change reloads it to 1.
  - When the counter reaches STABLE_CNT, the pattern is accepted once. The counter saturates, so there is no re-accept until the inputs change.
- Accepted sample classification:
  - AN = 4'hF (blanking gap): ignored.
  - Exactly one AN bit low: decode LED into shadow[i] and set seen[i].
  - Two or more AN bits low: set the shadow an_err bit; no digit is written.
- Decode (LED hex → digit):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 7F (blank) → 4'hF.
  - Any other pattern → 4'hE, and the shadow seg_err bit is set.
- A repeat accept of an already-seen digit overwrites shadow[i]; seen is unchanged.
- Frame commit, on the cycle after seen becomes 4'hF:
  - Copy shadow to digit0..3 and the shadow error bits to seg_err/an_err.
  - Pulse frame_valid.
  - Clear seen and the shadow error bits.
- FSM states:
  - COLLECT: default state.
  - COMMIT: entered when seen = 4'hF; lasts exactly one cycle, then returns to COLLECT.
  - An accept that arrives during COMMIT is applied to the new frame.

## Timing
- Reset values:
  - digit0..3 = 4'hF.
  - frame_valid, seg_err, an_err, scan_stall = 0.
  - seen = 0, shadow = 4'hF, synchronizers = all ones, stability counter = 0, FSM = COLLECT.
- Latency:
  - Pin change at edge 0 appears synchronized at edge 2.
  - The accept occurs at edge 2+STABLE_CNT−1; shadow and seen are written on that edge.
  - If that accept completes seen, frame_valid is high during the following cycle.
- Glitch handling: a pattern held for fewer than STABLE_CNT synchronized cycles is never accepted.
- Reset asserted mid-frame discards the partial frame immediately, asynchronously.
- Outputs hold their values between commits.

## Configuration
- SEG_SCAN_TIMEOUT_EN defined:
  - A cycle counter is cleared on reset and on each frame_valid. When it reaches TIMEOUT_CYCLES, scan_stall is set.
  - scan_stall clears on the next frame_valid. The counter saturates.
- Macro undefined:
  - The counter logic is absent and the scan_stall port is absent.

## Test plan
- Scan digits 1,2,3,4 on AN = E,D,B,7, each held 8 cycles with 2-cycle 4'hF gaps → one frame_valid pulse; digit0..3 = 1,2,3,4; seg_err = an_err = 0.
- Same scan, but digit2 carries LED = 7'h3F held for 2 cycles and then 7'h30 held for 6 (STABLE_CNT=4) → digit2 = 3; no error.
- LED = 7'h55 on AN = 4'hB → frame commits with digit2 = 4'hE and seg_err = 1; the next clean frame clears seg_err.
- AN = 4'hC held 8 cycles inside a frame → an_err = 1 at commit; digits are unaffected.
- Reset pulsed after three digits are accepted, then one full scan → exactly one frame_valid with the new values; all outputs read 4'hF/0 during reset.
- With SEG_SCAN_TIMEOUT_EN and TIMEOUT_CYCLES = 100: hold AN = 4'hF for 150 cycles → scan_stall = 1 at cycle 100; a full scan clears it at frame_valid.
